// File: rtl/row_conv_ctrl.sv
// Row-convolution sequencer for one PE: loads a filter row and an activation row,
// then drives an external registered MAC one product per cycle and streams each psum out.
module row_conv_ctrl #(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32,
  parameter int S_MAX  = 5,
  parameter int W_MAX  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(S_MAX+1)-1:0]   cfg_s,
  input  logic [$clog2(W_MAX+1)-1:0]   cfg_w,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [DATA_W-1:0]            w_data,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [DATA_W-1:0]            a_data,
  output logic                         mac_en,
  output logic [DATA_W-1:0]            mac_a,
  output logic [DATA_W-1:0]            mac_w,
  output logic [DATA_W-1:0]            mac_sum,
  input  logic [PSUM_W-1:0]            mac_out,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic [PSUM_W-1:0]            psum_data,
  output logic [$clog2(W_MAX)-1:0]     psum_idx
);

  localparam int SW = $clog2(S_MAX + 1);
  localparam int AW = $clog2(W_MAX + 1);
  localparam int IW = $clog2(W_MAX);
  localparam int WI = (S_MAX > 1) ? $clog2(S_MAX) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, DONE} state_t;

  state_t            state_q, state_n;
  logic [SW-1:0]     s_len_q, s_len_n, s_q, s_n, w_cnt_q, w_cnt_n;
  logic [AW-1:0]     w_len_q, w_len_n, a_cnt_q, a_cnt_n;
  logic [IW-1:0]     ox_q, ox_n;

  logic [DATA_W-1:0] wgt [S_MAX];
  logic [DATA_W-1:0] act [W_MAX];

  logic              cfg_ok, w_hs, a_hs, loaded, last_s, last_ox;
  logic [IW-1:0]     a_addr;
  logic [WI-1:0]     w_addr;

  logic              busy_d, done_d, cfg_err_d, w_ready_d, a_ready_d, mac_en_d, psum_valid_d;
  logic [DATA_W-1:0] mac_a_d, mac_w_d;
  logic [IW-1:0]     psum_idx_d;

  assign cfg_ok  = (cfg_s != '0) && (cfg_s <= SW'(S_MAX)) &&
                   (AW'(cfg_s) <= cfg_w) && (cfg_w <= AW'(W_MAX));
  assign w_hs    = w_valid && w_ready;
  assign a_hs    = a_valid && a_ready;
  assign loaded  = (w_cnt_q == s_len_q) && (a_cnt_q == w_len_q);
  assign last_s  = (s_q == s_len_q - SW'(1));
  assign last_ox = (ox_q == IW'(w_len_q - AW'(s_len_q)));

  // s_q is the tap index of the product on mac_a/mac_w this cycle; tap 0 starts a fresh sum.
  assign mac_sum   = (mac_en && (s_q != '0)) ? mac_out[DATA_W-1:0] : '0;
  // mac_out is frozen while mac_en is low, so the psum is forwarded without a re-register.
  assign psum_data = mac_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s_len_q    <= '0;
      w_len_q    <= '0;
      s_q        <= '0;
      ox_q       <= '0;
      w_cnt_q    <= '0;
      a_cnt_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      w_ready    <= 1'b0;
      a_ready    <= 1'b0;
      mac_en     <= 1'b0;
      mac_a      <= '0;
      mac_w      <= '0;
      psum_valid <= 1'b0;
      psum_idx   <= '0;
    end else begin
      state_q    <= state_n;
      s_len_q    <= s_len_n;
      w_len_q    <= w_len_n;
      s_q        <= s_n;
      ox_q       <= ox_n;
      w_cnt_q    <= w_cnt_n;
      a_cnt_q    <= a_cnt_n;
      busy       <= busy_d;
      done       <= done_d;
      cfg_err    <= cfg_err_d;
      w_ready    <= w_ready_d;
      a_ready    <= a_ready_d;
      mac_en     <= mac_en_d;
      mac_a      <= mac_a_d;
      mac_w      <= mac_w_d;
      psum_valid <= psum_valid_d;
      psum_idx   <= psum_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && w_hs) wgt[WI'(w_cnt_q)] <= w_data;
    if ((state_q == LOAD) && a_hs) act[IW'(a_cnt_q)] <= a_data;
  end

  always_comb begin
    state_n = state_q;
    s_len_n = s_len_q;
    w_len_n = w_len_q;
    s_n     = s_q;
    ox_n    = ox_q;
    w_cnt_n = w_cnt_q;
    a_cnt_n = a_cnt_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          state_n = LOAD;
          s_len_n = cfg_s;
          w_len_n = cfg_w;
          w_cnt_n = '0;
          a_cnt_n = '0;
          s_n     = '0;
          ox_n    = '0;
        end
      end
      LOAD: begin
        if (w_hs) w_cnt_n = w_cnt_q + SW'(1);
        if (a_hs) a_cnt_n = a_cnt_q + AW'(1);
        if (loaded) begin
          state_n = COMPUTE;
          s_n     = '0;
          ox_n    = '0;
        end
      end
      COMPUTE: begin
        if (last_s) state_n = OUTPUT;
        else        s_n     = s_q + SW'(1);
      end
      OUTPUT: begin
        if (psum_ready) begin
          if (last_ox) begin
            state_n = DONE;
          end else begin
            state_n = COMPUTE;
            ox_n    = ox_q + IW'(1);
            s_n     = '0;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they register in step with state_q.
  always_comb begin
    a_addr       = IW'(AW'(ox_n) + AW'(s_n));
    w_addr       = WI'(s_n);
    busy_d       = (state_n != IDLE);
    done_d       = (state_n == DONE);
    cfg_err_d    = (state_q == IDLE) && start && !cfg_ok;
    w_ready_d    = (state_n == LOAD) && (w_cnt_n != s_len_n);
    a_ready_d    = (state_n == LOAD) && (a_cnt_n != w_len_n);
    mac_en_d     = (state_n == COMPUTE);
    mac_a_d      = mac_en_d ? act[a_addr] : '0;
    mac_w_d      = mac_en_d ? wgt[w_addr] : '0;
    psum_valid_d = (state_n == OUTPUT);
    psum_idx_d   = psum_valid_d ? ox_n : '0;
  end

endmodule

// File: tb/tb_row_conv_ctrl.sv
// Self-checking bench for row_conv_ctrl: models the external MAC and compares each psum
// against a direct arithmetic evaluation of the 1-D valid convolution.
module tb_row_conv_ctrl;

  localparam int DATA_W = 16;
  localparam int PSUM_W = 32;
  localparam int S_MAX  = 5;
  localparam int W_MAX  = 16;
  localparam int SW = $clog2(S_MAX + 1);
  localparam int AW = $clog2(W_MAX + 1);
  localparam int IW = $clog2(W_MAX);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [SW-1:0]     cfg_s = '0;
  logic [AW-1:0]     cfg_w = '0;
  logic              busy, done, cfg_err;
  logic              w_valid = 1'b0, w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              a_valid = 1'b0, a_ready;
  logic [DATA_W-1:0] a_data = '0;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a, mac_w, mac_sum;
  logic [PSUM_W-1:0] mac_out;
  logic              psum_valid, psum_ready = 1'b1;
  logic [PSUM_W-1:0] psum_data;
  logic [IW-1:0]     psum_idx;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] wv [S_MAX];
  logic [DATA_W-1:0] av [W_MAX];
  logic [PSUM_W-1:0] exp_ps [W_MAX];

  row_conv_ctrl #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .S_MAX(S_MAX), .W_MAX(W_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_s(cfg_s), .cfg_w(cfg_w),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .mac_en(mac_en), .mac_a(mac_a), .mac_w(mac_w), .mac_sum(mac_sum), .mac_out(mac_out),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data), .psum_idx(psum_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External MAC: registered out = a*w + sum, holds when disabled.
  always @(posedge clk) begin
    if (reset)       mac_out <= '0;
    else if (mac_en) mac_out <= {16'b0, mac_a} * {16'b0, mac_w} + {16'b0, mac_sum};
  end

  // Each output sums products left to right; the running sum handed back is its low 16 bits.
  function automatic void model(input int s, input int w);
    logic [31:0] full;
    logic [15:0] acc;
    for (int ox = 0; ox <= w - s; ox++) begin
      acc  = '0;
      full = '0;
      for (int k = 0; k < s; k++) begin
        full = 32'(wv[k]) * 32'(av[ox + k]) + 32'(acc);
        acc  = full[15:0];
      end
      exp_ps[ox] = full;
    end
  endfunction

  task automatic load_basic_data;
    wv[0] = 16'd1; wv[1] = 16'd2; wv[2] = 16'd3;
    for (int i = 0; i < 5; i++) av[i] = 16'(i + 1);
    exp_ps[0] = 32'd14; exp_ps[1] = 32'd20; exp_ps[2] = 32'd26;
  endtask

  // mode 0: continuous, 1: random gaps, 2: every other cycle. last_at holds back the final element.
  task automatic drive_stream(input bit is_w, input int n, input int mode, input int dly, input int last_at);
    int i = 0;
    int rel = 0;
    int guard = 0;
    bit show, hs, rdy;
    repeat (dly) begin @(posedge clk); #1; rel++; end
    while (i < n && guard < 1000) begin
      case (mode)
        0:       show = 1'b1;
        1:       show = ($urandom_range(0, 1) == 1);
        default: show = ((rel % 2) == 0);
      endcase
      if (i == n - 1 && rel < last_at) show = 1'b0;
      if (is_w) begin
        w_valid = show;
        w_data  = show ? wv[i] : 16'($urandom);
      end else begin
        a_valid = show;
        a_data  = show ? av[i] : 16'($urandom);
      end
      @(negedge clk);
      hs = is_w ? (w_valid && w_ready) : (a_valid && a_ready);
      @(posedge clk); #1;
      rel++;
      guard++;
      if (hs) i++;
    end
    if (is_w) w_valid = 1'b0; else a_valid = 1'b0;
    checks++;
    if (i != n) begin
      fails++;
      $display("FAIL load_timeout(%s): accepted %0d required %0d", is_w ? "w" : "a", i, n);
    end else begin
      rdy = is_w ? w_ready : a_ready;
      checks++;
      if (rdy !== 1'b0) begin
        fails++;
        $display("FAIL ready_after_count(%s): got %b required 0", is_w ? "w" : "a", rdy);
      end
    end
  endtask

  task automatic collect(input string name, input int s, input int n, input int stall_idx, input int stall_len);
    int got = 0;
    int guard = 0;
    int stall_cnt = 0;
    int last_cyc = -1;
    psum_ready = (stall_idx != 0);
    while (got < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      checks++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s early_done: got %b required 0 at output %0d", name, done, got);
      end
      if (psum_valid === 1'b1) begin
        checks++;
        if (psum_data !== exp_ps[got] || psum_idx !== IW'(got) || mac_en !== 1'b0) begin
          fails++;
          $display("FAIL %s psum[%0d]: got data=%0d idx=%0d mac_en=%b required data=%0d idx=%0d mac_en=0",
                   name, got, psum_data, psum_idx, mac_en, exp_ps[got], got);
        end
        if (psum_ready) begin
          if (stall_idx < 0 && last_cyc >= 0) begin
            checks++;
            if (cyc - last_cyc != s + 1) begin
              fails++;
              $display("FAIL %s spacing[%0d]: got %0d cycles required %0d", name, got, cyc - last_cyc, s + 1);
            end
          end
          last_cyc = cyc;
          got++;
          @(posedge clk); #1;
          psum_ready = (got != stall_idx);
        end else begin
          stall_cnt++;
          if (stall_cnt == stall_len) begin
            @(posedge clk); #1;
            psum_ready = 1'b1;
          end
        end
      end
    end
    checks++;
    if (got != n) begin
      fails++;
      $display("FAIL %s psum_count: got %0d required %0d", name, got, n);
    end
    psum_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s done_pulse: got done=%b busy=%b required done=1 busy=1", name, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got done=%b busy=%b required done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic run_job(input string name, input int s, input int w, input int wmode, input int wdly,
                         input int amode, input int alast, input int stall_idx, input int stall_len,
                         input bit extra_start);
    @(posedge clk); #1;
    start = 1'b1; cfg_s = SW'(s); cfg_w = AW'(w);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b required 1", name, busy);
    end
    fork
      drive_stream(1'b1, s, wmode, wdly, -1);
      drive_stream(1'b0, w, amode, 0, alast);
      collect(name, s, w - s + 1, stall_idx, stall_len);
      begin
        if (extra_start) begin
          repeat (3) begin @(posedge clk); #1; end
          start = 1'b1; cfg_s = SW'(1); cfg_w = AW'(1);
          @(posedge clk); #1;
          start = 1'b0;
          @(negedge clk);
          checks++;
          if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s start_in_load: got cfg_err=%b busy=%b required 0,1", name, cfg_err, busy);
          end
        end
      end
    join
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cfg_err, w_ready, a_ready, mac_en, psum_valid} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, done, cfg_err, w_ready, a_ready, mac_en, psum_valid});
    end
    checks++;
    if (mac_a !== '0 || mac_w !== '0 || mac_sum !== '0 || psum_idx !== '0) begin
      fails++;
      $display("FAIL reset_data: got a=%0d w=%0d sum=%0d idx=%0d required all 0", mac_a, mac_w, mac_sum, psum_idx);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    load_basic_data();
    run_job("basic", 3, 5, 0, 0, 0, -1, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    load_basic_data();
    run_job("backpressure", 3, 5, 0, 0, 0, -1, 1, 4, 1'b0);
  endtask

  task automatic test_edge_sizes;
    wv[0] = 16'd7; av[0] = 16'd6; exp_ps[0] = 32'd42;
    run_job("edge_1x1", 1, 1, 0, 0, 0, -1, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin wv[i] = 16'd1; av[i] = 16'(i + 2); end
    exp_ps[0] = 32'd14;
    run_job("edge_4x4", 4, 4, 1, 0, 1, -1, -1, 0, 1'b0);
  endtask

  task automatic test_illegal;
    int cs [2] = '{0, 4};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; cfg_s = SW'(cs[k]); cfg_w = AW'(3);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || w_ready !== 1'b0 || a_ready !== 1'b0) begin
        fails++;
        $display("FAIL illegal_s%0d: got cfg_err=%b busy=%b w_ready=%b a_ready=%b required 1,0,0,0",
                 cs[k], cfg_err, busy, w_ready, a_ready);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL illegal_after_s%0d: got cfg_err=%b busy=%b required 0,0", cs[k], cfg_err, busy);
      end
    end
  endtask

  task automatic test_load_order;
    load_basic_data();
    run_job("load_order", 3, 5, 0, 10, 2, 10, -1, 0, 1'b1);
  endtask

  task automatic test_mid_reset;
    int guard = 0;
    load_basic_data();
    @(posedge clk); #1;
    start = 1'b1; cfg_s = SW'(3); cfg_w = AW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    psum_ready = 1'b1;
    fork
      drive_stream(1'b1, 3, 0, 0, -1);
      drive_stream(1'b0, 5, 0, 0, -1);
    join
    @(negedge clk);
    while (psum_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (psum_valid !== 1'b1 || psum_data !== 32'd14) begin
      fails++;
      $display("FAIL mid_reset_first: got valid=%b data=%0d required 1,14", psum_valid, psum_data);
    end
    @(negedge clk);
    checks++;
    if (mac_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_compute: got mac_en=%b required 1", mac_en);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, cfg_err, w_ready, a_ready, mac_en, psum_valid} !== 7'b0 ||
        mac_a !== '0 || mac_w !== '0 || mac_sum !== '0 || psum_idx !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got ctrl=%b a=%0d w=%0d sum=%0d idx=%0d required all 0",
               {busy, done, cfg_err, w_ready, a_ready, mac_en, psum_valid}, mac_a, mac_w, mac_sum, psum_idx);
    end
    run_job("after_reset", 3, 5, 0, 0, 0, -1, -1, 0, 1'b0);
  endtask

  task automatic test_random;
    int s, w, n, sidx, slen;
    for (int j = 0; j < 8; j++) begin
      s = $urandom_range(1, S_MAX);
      w = $urandom_range(s, W_MAX);
      n = w - s + 1;
      for (int i = 0; i < S_MAX; i++) wv[i] = (j < 4) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      for (int i = 0; i < W_MAX; i++) av[i] = (j < 4) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      model(s, w);
      sidx = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, n - 1);
      slen = $urandom_range(1, 4);
      run_job($sformatf("random%0d", j), s, w, 1, $urandom_range(0, 3), 1, -1, sidx, slen, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_sizes();
    test_illegal();
    test_load_order();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
